// File: rtl/dmem_lsu.sv
// Load/store unit between the MEM stage and a 256-word asynchronous-read data memory.
// Handles alignment errors, lane selection, load extension and read-modify-write for SB/SH.
module dmem_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q;
  logic [2:0]              funct3_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    accept;
  logic                    req_err;

  // Only the low byte-address bits reach the memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic e;
    e = 1'b0;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = |a;
      3'b100:  e = we;
      3'b101:  e = we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [DATA_WIDTH-1:0] word,
                                                     input logic [2:0] f3,
                                                     input logic [1:0] a);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    r = '0;
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = '0;
    endcase
    return r;
  endfunction

  // req_ready is gated by rst_n so nothing is accepted while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_err   = is_illegal(req_we, req_funct3, req_addr[1:0]);
  assign rsp_valid = (state_q == RESP);
  assign mem_a     = addr_q[ADDR_WIDTH-1:2];
  assign mem_we    = rst_n && (state_q == WRITE);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    merged = rd_q;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign mem_wd = (state_q == WRITE) ? merged : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                            state_d = RESP;
          else if (req_we && req_funct3 == 3'b010) state_d = WRITE;
          else                                    state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr[ADDR_WIDTH-1:0];
        wdata_q  <= req_wdata;
      end
      if (state_q == READ) rd_q <= mem_rd;
      // Response fields are loaded on the edge entering RESP and cleared on every other edge.
      rsp_err   <= accept && req_err;
      rsp_rdata <= (state_q == READ && !we_q) ? load_ext(mem_rd, funct3_q, addr_q[1:0]) : '0;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: word-level memory model plus directed transactions.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [7:0]  mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;

  logic [31:0] ram       [256];
  logic [31:0] model_mem [256];

  dmem_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  // Backing data memory: asynchronous read, synchronous write.
  assign mem_rd = ram[mem_a];
  always @(posedge clk) if (mem_we) ram[mem_a] <= mem_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Model state: at most one request in flight.
  bit          pend, we_pend;
  int          due, we_due;
  logic [31:0] exp_rd, exp_wd;
  logic        exp_err;
  logic [7:0]  exp_idx, exp_widx;
  int          we_cnt, rsp_cnt;
  logic [31:0] last_we_a;

  task automatic model_accept();
    int unsigned size, sh, lat;
    logic [31:0] w, mask, lane;
    logic        err;
    case (req_funct3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    err = (size == 0) || (req_funct3[2] && (req_we || size == 4)) || (req_addr % size != 0);
    w    = model_mem[req_addr[9:2]];
    sh   = 8 * (req_addr % 4);
    mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    exp_idx = req_addr[9:2];
    exp_err = err;
    exp_rd  = '0;
    if (err) lat = 1;
    else if (!req_we) begin
      lane = (w >> sh) & mask;
      if (!req_funct3[2] && size < 4 && lane[8*size-1]) lane = lane | ~mask;
      exp_rd = lane;
      lat = 2;
    end else begin
      exp_wd   = (w & ~(mask << sh)) | ((req_wdata & mask) << sh);
      exp_widx = req_addr[9:2];
      we_pend  = 1;
      we_due   = ncyc + ((size == 4) ? 1 : 2);
      lat      = (size == 4) ? 2 : 3;
    end
    pend = 1;
    due  = ncyc + lat;
  endtask

  // Compare process: checks every DUT output on every falling edge against the model.
  initial begin
    bit rv, wv, rdy;
    pend = 0; we_pend = 0; exp_idx = 0; we_cnt = 0; rsp_cnt = 0; last_we_a = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);
        pend = 0; we_pend = 0; exp_idx = 0;
      end else begin
        rv  = pend && (ncyc == due);
        wv  = we_pend && (ncyc == we_due);
        rdy = !pend;
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, rv});
        check("rsp_rdata", rsp_rdata, rv ? exp_rd : 32'd0);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, rv && exp_err});
        check("mem_we", {31'd0, mem_we}, {31'd0, wv});
        check("mem_wd", mem_wd, wv ? exp_wd : 32'd0);
        check("mem_a", {24'd0, mem_a}, {24'd0, wv ? exp_widx : exp_idx});
        check("req_ready", {31'd0, req_ready}, {31'd0, rdy});
        if (mem_we) begin we_cnt++; last_we_a = {24'd0, mem_a}; end
        if (rsp_valid) rsp_cnt++;
        if (wv) begin model_mem[exp_widx] = exp_wd; we_pend = 0; end
        if (rv) pend = 0;
        if (req_valid && rdy) model_accept();
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e,
                        output int lat);
    int g;
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 10) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    // Once accepted the request fields must be ignored.
    req_valid = 0; req_we = ~we; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 8);
    rd = rsp_rdata;
    e  = rsp_err;
  endtask

  task automatic xact(input string name, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_data,
                      input logic exp_e, input int exp_lat);
    logic [31:0] rd;
    logic        e;
    int          lat;
    do_req(we, f3, a, wd, rd, e, lat);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_rdata"}, rd, exp_data);
    check({name, "_err"}, {31'd0, e}, {31'd0, exp_e});
  endtask

  initial begin
    int         w0, r0, g;
    int         acc [4];
    logic [31:0] qa [4];
    for (int i = 0; i < 256; i++) begin ram[i] = '0; model_mem[i] = '0; end
    rst_n = 0; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("post_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_reset_rsp_rdata", rsp_rdata, 32'd0);
    check("post_reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_reset_mem_a", {24'd0, mem_a}, 32'd0);

    w0 = we_cnt;
    xact("sw_deadbeef", 1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 0, 2);
    check("sw_we_pulses", we_cnt - w0, 1);
    check("sw_we_addr", last_we_a, 32'd4);
    xact("lw_deadbeef", 0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 0, 2);

    xact("sw_11223344", 1, 3'b010, 32'h010, 32'h11223344, 32'h0, 0, 2);
    w0 = we_cnt;
    xact("sb_ab", 1, 3'b000, 32'h012, 32'h555555AB, 32'h0, 0, 3);
    check("sb_we_pulses", we_cnt - w0, 1);
    xact("lw_after_sb", 0, 3'b010, 32'h010, 32'h0, 32'h11AB3344, 0, 2);

    xact("sw_8080", 1, 3'b010, 32'h000, 32'h00008080, 32'h0, 0, 2);
    xact("lb_8080", 0, 3'b000, 32'h000, 32'h0, 32'hFFFFFF80, 0, 2);
    xact("lbu_8080", 0, 3'b100, 32'h000, 32'h0, 32'h00000080, 0, 2);
    xact("lh_8080", 0, 3'b001, 32'h000, 32'h0, 32'hFFFF8080, 0, 2);
    xact("lhu_8080_hi", 0, 3'b101, 32'h002, 32'h0, 32'h00000000, 0, 2);

    // Every lane and extension flavour on word 4; the model checks the data.
    for (int off = 0; off < 4; off++) begin
      logic [31:0] rd; logic e; int lat;
      do_req(0, 3'b000, 32'h010 + off, 0, rd, e, lat);
      do_req(0, 3'b100, 32'h010 + off, 0, rd, e, lat);
      do_req(0, 3'b001, 32'h010 + off, 0, rd, e, lat);
      do_req(0, 3'b101, 32'h010 + off, 0, rd, e, lat);
    end
    xact("sh_hi_half", 1, 3'b001, 32'h402, 32'hFFFF9876, 32'h0, 0, 3);
    xact("lh_hi_half", 0, 3'b001, 32'h002, 32'h0, 32'hFFFF9876, 0, 2);

    w0 = we_cnt;
    xact("sh_misaligned", 1, 3'b001, 32'h011, 32'h0000CAFE, 32'h0, 1, 1);
    check("sh_misaligned_no_we", we_cnt - w0, 0);
    xact("word4_unchanged", 0, 3'b010, 32'h010, 32'h0, 32'h11AB3344, 0, 2);
    xact("lw_misaligned", 0, 3'b010, 32'h002, 32'h0, 32'h0, 1, 1);
    xact("funct3_011", 0, 3'b011, 32'h000, 32'h0, 32'h0, 1, 1);
    xact("store_f3_100", 1, 3'b100, 32'h000, 32'h0, 32'h0, 1, 1);
    xact("lhu_odd", 0, 3'b101, 32'h003, 32'h0, 32'h0, 1, 1);

    // Reset asserted during the WRITE cycle of an SB.
    xact("sw_reset_word", 1, 3'b010, 32'h020, 32'h01020304, 32'h0, 0, 2);
    w0 = we_cnt; r0 = rsp_cnt;
    @(posedge clk); #1;
    req_valid = 1; req_we = 1; req_funct3 = 3'b000; req_addr = 32'h021; req_wdata = 32'hFF;
    @(negedge clk);
    check("rst_sb_accept_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("rst_ready_back", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("rst_no_we", we_cnt - w0, 0);
    check("rst_no_rsp", rsp_cnt - r0, 0);
    xact("rst_word_unchanged", 0, 3'b010, 32'h020, 32'h0, 32'h01020304, 0, 2);

    // Back-to-back loads with req_valid held high.
    qa[0] = 32'h010; qa[1] = 32'h020; qa[2] = 32'h000; qa[3] = 32'h404;
    r0 = rsp_cnt;
    @(posedge clk); #1;
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = qa[0];
    for (int k = 0; k < 4; k++) begin
      g = 0;
      @(negedge clk);
      while (!req_ready && g < 10) begin @(negedge clk); g++; end
      acc[k] = ncyc;
      @(posedge clk); #1;
      if (k < 3) req_addr = qa[k+1];
      else req_valid = 0;
    end
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) check("queued_accept_gap", acc[k+1] - acc[k], 3);
    check("queued_rsp_count", rsp_cnt - r0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
